// File: rtl/toggle_monitor_pkg.sv
// Shared definitions for the toggle link receiver: FSM encodings, width helper, defaults.
package toggle_monitor_pkg;

    // Expected half-period for a 1 Hz toggle on a 25 MHz fabric clock
    localparam int unsigned DEFAULT_CLK_FREQ = 25_000_000;

    // Measurement FSM encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    // Ceiling log2; returns at least 1 so derived widths are never zero
    function automatic int unsigned clog2_f(input longint unsigned value);
        int unsigned     bits;
        longint unsigned rem;
        bits = 0;
        rem  = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/toggle_monitor_edge_sync.sv
// Synchronises the asynchronous toggle level and produces a registered edge pulse.
// Ports:
//   iClk, iRst  clock, synchronous active-high reset
//   toggle_i    asynchronous toggling level
//   level_o     synchronised level (2-cycle latency)
//   edge_o      1-cycle pulse per level change, suppressed while the arm counter fills
module toggle_monitor_edge_sync
    import toggle_monitor_pkg::*;
(
    input  logic iClk,
    input  logic iRst,
    input  logic toggle_i,
    output logic level_o,
    output logic edge_o
);

    localparam logic [1:0] ARM_DONE = 2'd3;

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic [1:0] arm_q;
    logic [1:0] arm_d;
    logic       edge_q;
    logic       edge_d;

    // Arm gate hides the 0->1 step seen when the pin is already high at reset release
    always_comb begin
        arm_d  = (arm_q == ARM_DONE) ? arm_q : arm_q + 2'd1;
        edge_d = (arm_q == ARM_DONE) && (sync2_q ^ prev_q);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            arm_q   <= 2'd0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= toggle_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            arm_q   <= arm_d;
            edge_q  <= edge_d;
        end
    end

    assign level_o = sync2_q;
    assign edge_o  = edge_q;

endmodule

// File: rtl/toggle_monitor.sv
// Receive end of the 1 Hz toggle link: measures the half-period between edges,
// reports lock when two consecutive periods match CLK_FREQ, and timeout when edges stop.
// Ports:
//   iClk, iRst    clock, synchronous active-high reset
//   iToggle       asynchronous toggling level
//   oLevel        synchronised level
//   oEdge         1-cycle pulse per accepted edge
//   oPeriod       last measured half-period in iClk cycles
//   oPeriodValid  1-cycle pulse when oPeriod updates
//   oLocked       two consecutive matching measurements
//   oTimeout      no edge within TIMEOUT_CYCLES
module toggle_monitor
    import toggle_monitor_pkg::*;
#(
    parameter  int unsigned CLK_FREQ       = DEFAULT_CLK_FREQ,
    parameter  int unsigned TOL_CYCLES     = 1024,
    parameter  int unsigned TIMEOUT_CYCLES = 2 * CLK_FREQ,
    localparam int unsigned CNT_W          = clog2_f(longint'(TIMEOUT_CYCLES) + 1)
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iToggle,
    output logic             oLevel,
    output logic             oEdge,
    output logic [CNT_W-1:0] oPeriod,
    output logic             oPeriodValid,
    output logic             oLocked,
    output logic             oTimeout
);

    localparam int unsigned      MATCH_LO_INT = (TOL_CYCLES > CLK_FREQ) ? 0 : CLK_FREQ - TOL_CYCLES;
    localparam logic [CNT_W:0]   MATCH_LO     = (CNT_W+1)'(MATCH_LO_INT);
    localparam logic [CNT_W:0]   MATCH_HI     = (CNT_W+1)'(CLK_FREQ + TOL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [1:0]       LOCK_CNT     = 2'd2;

    logic             edge_c;
    logic             level_c;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       match_q,   match_d;
    logic             edge_q,    edge_d;
    logic [CNT_W-1:0] period_q,  period_d;
    logic             valid_q,   valid_d;
    logic             locked_q,  locked_d;
    logic             timeout_q, timeout_d;

    logic [CNT_W-1:0] period_c;
    logic             match_c;

    toggle_monitor_edge_sync u_edge_sync (
        .iClk     (iClk),
        .iRst     (iRst),
        .toggle_i (iToggle),
        .level_o  (level_c),
        .edge_o   (edge_c)
    );

    // Period ending at this cycle; cnt_q never exceeds CNT_MAX so this cannot wrap
    assign period_c = cnt_q + CNT_W'(1);
    assign match_c  = ({1'b0, period_c} >= MATCH_LO) && ({1'b0, period_c} <= MATCH_HI);

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        match_d   = match_q;
        edge_d    = edge_c;
        period_d  = period_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (edge_c) begin
                    // First edge only opens a measurement window
                    cnt_d   = '0;
                    state_d = ST_MEASURE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                    match_d   = 2'd0;
                    locked_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_MEASURE: begin
                if (cnt_q == CNT_MAX) begin
                    // Period would exceed the limit: an edge here is too late to count
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                    match_d   = 2'd0;
                    locked_d  = 1'b0;
                    if (edge_c) begin
                        cnt_d = '0;
                    end
                end else if (edge_c) begin
                    cnt_d    = '0;
                    period_d = period_c;
                    valid_d  = 1'b1;
                    if (match_c) begin
                        match_d = (match_q == LOCK_CNT) ? LOCK_CNT : match_q + 2'd1;
                    end else begin
                        match_d = 2'd0;
                    end
                    locked_d = (match_d == LOCK_CNT);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_TIMEOUT: begin
                // Counter held; the next edge restarts measurement without a result
                if (edge_c) begin
                    cnt_d     = '0;
                    state_d   = ST_MEASURE;
                    timeout_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            match_q   <= 2'd0;
            edge_q    <= 1'b0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            edge_q    <= edge_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign oLevel       = level_c;
    assign oEdge        = edge_q;
    assign oPeriod      = period_q;
    assign oPeriodValid = valid_q;
    assign oLocked      = locked_q;
    assign oTimeout     = timeout_q;

endmodule

// File: tb/tb_toggle_monitor.sv
// Scoreboard bench for toggle_monitor: stimulus pushes hand-computed expected events,
// a negedge monitor pops and compares whenever the DUT emits an edge, a valid or a timeout.
module tb_toggle_monitor;

    localparam int unsigned CLK_FREQ = 100;
    localparam int unsigned TOL      = 2;
    localparam int unsigned TMO      = 200;

    logic       iClk;
    logic       iRst;
    logic       iToggle;
    logic       oLevel;
    logic       oEdge;
    logic [7:0] oPeriod;
    logic       oPeriodValid;
    logic       oLocked;
    logic       oTimeout;

    typedef struct {
        int unsigned cyc;
        logic        ev_edge;
        logic        valid;
        logic [7:0]  period;
        logic        locked;
        logic        timeout;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int unsigned last_edge_cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    toggle_monitor #(
        .CLK_FREQ       (CLK_FREQ),
        .TOL_CYCLES     (TOL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iToggle      (iToggle),
        .oLevel       (oLevel),
        .oEdge        (oEdge),
        .oPeriod      (oPeriod),
        .oPeriodValid (oPeriodValid),
        .oLocked      (oLocked),
        .oTimeout     (oTimeout)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    always @(posedge iClk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Toggle after gap cycles; the edge pulse is due 4 cycle counts after the drive
    task automatic tog(input int gap, input logic v, input logic [7:0] p, input logic l, input logic t);
        exp_t e;
        repeat (gap) @(posedge iClk);
        #1;
        iToggle   = ~iToggle;
        e.cyc     = cyc + 4;
        e.ev_edge = 1'b1;
        e.valid   = v;
        e.period  = p;
        e.locked  = l;
        e.timeout = t;
        last_edge_cyc = e.cyc;
        sb_q.push_back(e);
    endtask

    task automatic push_timeout(input logic [7:0] p);
        exp_t e;
        e.cyc     = last_edge_cyc + TMO + 1;
        e.ev_edge = 1'b0;
        e.valid   = 1'b0;
        e.period  = p;
        e.locked  = 1'b0;
        e.timeout = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_edge"},    32'(oEdge),        32'd0);
        chk({tag, "_period"},  32'(oPeriod),      32'd0);
        chk({tag, "_valid"},   32'(oPeriodValid), 32'd0);
        chk({tag, "_locked"},  32'(oLocked),      32'd0);
        chk({tag, "_timeout"}, 32'(oTimeout),     32'd0);
    endtask

    // Monitor: any output event must match the head of the scoreboard
    initial begin
        exp_t e;
        logic tmo_prev;
        tmo_prev = 1'b0;
        forever begin
            @(negedge iClk);
            if (iRst !== 1'b1 &&
                (oEdge === 1'b1 || oPeriodValid === 1'b1 || (oTimeout === 1'b1 && !tmo_prev))) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: edge=%0b valid=%0b period=%0d timeout=%0b at cycle %0d",
                             oEdge, oPeriodValid, oPeriod, oTimeout, cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("event_cycle",   cyc,                e.cyc);
                    chk("event_edge",    32'(oEdge),         32'(e.ev_edge));
                    chk("event_valid",   32'(oPeriodValid),  32'(e.valid));
                    chk("event_period",  32'(oPeriod),       32'(e.period));
                    chk("event_locked",  32'(oLocked),       32'(e.locked));
                    chk("event_timeout", 32'(oTimeout),      32'(e.timeout));
                end
            end
            tmo_prev = (oTimeout === 1'b1);
        end
    end

    initial begin
        iRst    = 1'b1;
        iToggle = 1'b1;

        // 1: level high through reset must not produce an edge
        repeat (3) @(posedge iClk);
        #1;
        check_all_zero("reset");
        chk("reset_level", 32'(oLevel), 32'd0);
        iRst = 1'b0;
        @(posedge iClk); #1;
        chk("level_lat1", 32'(oLevel), 32'd0);
        @(posedge iClk); #1;
        chk("level_lat2", 32'(oLevel), 32'd1);
        repeat (8) @(posedge iClk);
        #1;
        check_all_zero("held_high");

        // 2: nominal toggling locks on the third edge
        tog(1,   1'b0, 8'd0,   1'b0, 1'b0);
        tog(100, 1'b1, 8'd100, 1'b0, 1'b0);
        tog(100, 1'b1, 8'd100, 1'b1, 1'b0);

        // 3: one out-of-tolerance period drops lock, two good ones relock
        tog(103, 1'b1, 8'd103, 1'b0, 1'b0);
        tog(100, 1'b1, 8'd100, 1'b0, 1'b0);
        tog(100, 1'b1, 8'd100, 1'b1, 1'b0);

        // 4: stop toggling -> timeout, then resume
        push_timeout(8'd100);
        tog(250, 1'b0, 8'd100, 1'b0, 1'b0);
        tog(100, 1'b1, 8'd100, 1'b0, 1'b0);
        tog(100, 1'b1, 8'd100, 1'b1, 1'b0);

        // 5: period exactly at the limit is valid; one more cycle times out
        tog(200, 1'b1, 8'd200, 1'b0, 1'b0);
        tog(201, 1'b0, 8'd200, 1'b0, 1'b1);
        tog(50,  1'b0, 8'd200, 1'b0, 1'b0);
        tog(100, 1'b1, 8'd100, 1'b0, 1'b0);
        tog(100, 1'b1, 8'd100, 1'b1, 1'b0);

        // 6: reset mid-measurement discards the partial count
        repeat (50) @(posedge iClk);
        #1;
        iRst = 1'b1;
        @(posedge iClk); #1;
        check_all_zero("midreset");
        chk("midreset_level", 32'(oLevel), 32'd0);
        iRst = 1'b0;
        tog(10,  1'b0, 8'd0,   1'b0, 1'b0);
        tog(100, 1'b1, 8'd100, 1'b0, 1'b0);
        tog(100, 1'b1, 8'd100, 1'b1, 1'b0);

        // Drain with a bounded wait
        for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge iClk);
        repeat (10) @(posedge iClk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
